rtc_calendar: RTL and testbench

- Parametrised real-time calendar counter; successor to the fixed 8-bit watch time block.
- Holds a full Gregorian year (YEAR_W bits), month, day, hour, minute, second and weekday, and advances once per 1-second strobe.
- Adds validated time loading, weekday tracking, a configurable year wrap, carry strobes and an h:m:s alarm.
- Sits between the 1 Hz tick generator and the display/BCD formatting logic.

---
 rtl/rtc_pkg.sv | 32 +++
 rtl/rtc_days_in_month.sv | 23 ++
 rtl/rtc_calendar.sv | 198 +++++++++++++++++++
 tb/tb_rtc_calendar.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants and helpers for the real-time calendar.
//   - Field widths for month/day/hour/minute/second/weekday.
//   - Month constants JAN..DEC.
//   - is_leap(): Gregorian leap-year test on an absolute year.
package rtc_pkg;

  localparam int unsigned MON_W  = 4;
  localparam int unsigned DAY_W  = 5;
  localparam int unsigned HR_W   = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned WDAY_W = 3;

  localparam logic [MON_W-1:0] JAN = 4'd1;
  localparam logic [MON_W-1:0] FEB = 4'd2;
  localparam logic [MON_W-1:0] MAR = 4'd3;
  localparam logic [MON_W-1:0] APR = 4'd4;
  localparam logic [MON_W-1:0] MAY = 4'd5;
  localparam logic [MON_W-1:0] JUN = 4'd6;
  localparam logic [MON_W-1:0] JUL = 4'd7;
  localparam logic [MON_W-1:0] AUG = 4'd8;
  localparam logic [MON_W-1:0] SEP = 4'd9;
  localparam logic [MON_W-1:0] OCT = 4'd10;
  localparam logic [MON_W-1:0] NOV = 4'd11;
  localparam logic [MON_W-1:0] DEC = 4'd12;

  function automatic logic is_leap(input logic [31:0] year);
    return ((year % 32'd4 == 32'd0) && (year % 32'd100 != 32'd0)) ||
           (year % 32'd400 == 32'd0);
  endfunction

endpackage

// File: rtl/rtc_days_in_month.sv
// rtc_days_in_month: combinational month length lookup.
//   month : month number, 1..12
//   leap  : the year in question is a leap year
//   days  : number of days in that month; 0 for an out-of-range month
module rtc_days_in_month
  import rtc_pkg::*;
(
  input  logic [MON_W-1:0] month,
  input  logic             leap,
  output logic [DAY_W-1:0] days
);

  always_comb begin
    days = '0;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: days = 5'd31;
      APR, JUN, SEP, NOV:                days = 5'd30;
      FEB:                               days = leap ? 5'd29 : 5'd28;
      default:                           days = '0;
    endcase
  end

endmodule

// File: rtl/rtc_calendar.sv
// rtc_calendar: Gregorian calendar/time-of-day counter advanced by a 1 s strobe.
//   clk, rst          : clock, asynchronous active-low reset
//   tick              : one-cycle 1 s strobe
//   set_en, set_*     : validated load of all fields (load beats a same-cycle tick)
//   alarm_en, alarm_* : h:m:s alarm compare against tick-caused updates
//   year..wday        : current calendar fields
//   leap              : current year is a leap year
//   min_carry         : pulse when a tick changes the minute
//   day_carry         : pulse when a tick rolls the day over
//   set_err           : pulse when a load is rejected
//   alarm_hit         : pulse registered with the tick update that hits the alarm
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int unsigned YEAR_W    = 16,
  parameter int unsigned YEAR_MIN  = 2000,
  parameter int unsigned YEAR_MAX  = 2399,
  parameter int unsigned RST_YEAR  = 2021,
  parameter int unsigned RST_MONTH = 5,
  parameter int unsigned RST_DAY   = 30,
  parameter int unsigned RST_WDAY  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              set_en,
  input  logic [YEAR_W-1:0] set_year,
  input  logic [MON_W-1:0]  set_month,
  input  logic [DAY_W-1:0]  set_day,
  input  logic [HR_W-1:0]   set_hour,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [SEC_W-1:0]  set_sec,
  input  logic [WDAY_W-1:0] set_wday,
  input  logic              alarm_en,
  input  logic [HR_W-1:0]   alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic [SEC_W-1:0]  alarm_sec,
  output logic [YEAR_W-1:0] year,
  output logic [MON_W-1:0]  month,
  output logic [DAY_W-1:0]  day,
  output logic [HR_W-1:0]   hour,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic [WDAY_W-1:0] wday,
  output logic              leap,
  output logic              min_carry,
  output logic              day_carry,
  output logic              set_err,
  output logic              alarm_hit
);

  localparam logic [YEAR_W-1:0] YearMinL = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] YearMaxL = YEAR_W'(YEAR_MAX);

  logic [YEAR_W-1:0] year_q,  year_d,  year_inc;
  logic [MON_W-1:0]  month_q, month_d, month_inc;
  logic [DAY_W-1:0]  day_q,   day_d,   day_inc;
  logic [HR_W-1:0]   hour_q,  hour_d,  hour_inc;
  logic [MIN_W-1:0]  min_q,   min_d,   min_inc;
  logic [SEC_W-1:0]  sec_q,   sec_d,   sec_inc;
  logic [WDAY_W-1:0] wday_q,  wday_d,  wday_inc;
  logic              min_carry_q, min_carry_d;
  logic              day_carry_q, day_carry_d;
  logic              set_err_q,   set_err_d;
  logic              alarm_hit_q, alarm_hit_d;

  logic [DAY_W-1:0] cur_dim, set_dim;
  logic             set_leap, set_valid, do_load, do_tick;
  logic             sec_wrap, min_wrap, hr_wrap, day_wrap, mon_wrap;

  assign leap     = is_leap(32'(year_q));
  assign set_leap = is_leap(32'(set_year));

  rtc_days_in_month u_cur_dim (
    .month (month_q),
    .leap  (leap),
    .days  (cur_dim)
  );

  rtc_days_in_month u_set_dim (
    .month (set_month),
    .leap  (set_leap),
    .days  (set_dim)
  );

  // set_dim is 0 for an illegal month, so the day bound also rejects it.
  assign set_valid = (set_month >= JAN) && (set_month <= DEC) &&
                     (set_day != '0) && (set_day <= set_dim) &&
                     (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59) &&
                     (set_wday <= 3'd6) &&
                     (set_year >= YearMinL) && (set_year <= YearMaxL);

  assign do_load = set_en && set_valid;
  // A rejected load leaves the tick to advance time as usual.
  assign do_tick = tick && !do_load;

  // Single carry chain from seconds up to the year.
  always_comb begin
    sec_wrap = (sec_q == 6'd59);
    min_wrap = sec_wrap && (min_q == 6'd59);
    hr_wrap  = min_wrap && (hour_q == 5'd23);
    day_wrap = hr_wrap && (day_q == cur_dim);
    mon_wrap = day_wrap && (month_q == DEC);

    sec_inc   = sec_wrap ? '0 : sec_q + 6'd1;
    min_inc   = min_q;
    hour_inc  = hour_q;
    day_inc   = day_q;
    month_inc = month_q;
    year_inc  = year_q;
    wday_inc  = wday_q;
    if (sec_wrap) min_inc = min_wrap ? '0 : min_q + 6'd1;
    if (min_wrap) hour_inc = hr_wrap ? '0 : hour_q + 5'd1;
    if (hr_wrap) begin
      day_inc  = day_wrap ? 5'd1 : day_q + 5'd1;
      wday_inc = (wday_q == 3'd6) ? '0 : wday_q + 3'd1;
    end
    if (day_wrap) month_inc = mon_wrap ? JAN : month_q + 4'd1;
    if (mon_wrap) year_inc = (year_q == YearMaxL) ? YearMinL : year_q + 1'b1;
  end

  always_comb begin
    year_d      = year_q;
    month_d     = month_q;
    day_d       = day_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    wday_d      = wday_q;
    min_carry_d = 1'b0;
    day_carry_d = 1'b0;
    set_err_d   = set_en && !set_valid;
    alarm_hit_d = 1'b0;
    if (do_load) begin
      year_d  = set_year;
      month_d = set_month;
      day_d   = set_day;
      hour_d  = set_hour;
      min_d   = set_min;
      sec_d   = set_sec;
      wday_d  = set_wday;
    end else if (do_tick) begin
      year_d      = year_inc;
      month_d     = month_inc;
      day_d       = day_inc;
      hour_d      = hour_inc;
      min_d       = min_inc;
      sec_d       = sec_inc;
      wday_d      = wday_inc;
      min_carry_d = sec_wrap;
      day_carry_d = hr_wrap;
      // Incremented fields are always legal, so illegal alarm values never match.
      alarm_hit_d = alarm_en && (hour_inc == alarm_hour) && (min_inc == alarm_min) &&
                    (sec_inc == alarm_sec);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      year_q      <= YEAR_W'(RST_YEAR);
      month_q     <= MON_W'(RST_MONTH);
      day_q       <= DAY_W'(RST_DAY);
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      wday_q      <= WDAY_W'(RST_WDAY);
      min_carry_q <= 1'b0;
      day_carry_q <= 1'b0;
      set_err_q   <= 1'b0;
      alarm_hit_q <= 1'b0;
    end else begin
      year_q      <= year_d;
      month_q     <= month_d;
      day_q       <= day_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      wday_q      <= wday_d;
      min_carry_q <= min_carry_d;
      day_carry_q <= day_carry_d;
      set_err_q   <= set_err_d;
      alarm_hit_q <= alarm_hit_d;
    end
  end

  assign year      = year_q;
  assign month     = month_q;
  assign day       = day_q;
  assign hour      = hour_q;
  assign minute    = min_q;
  assign second    = sec_q;
  assign wday      = wday_q;
  assign min_carry = min_carry_q;
  assign day_carry = day_carry_q;
  assign set_err   = set_err_q;
  assign alarm_hit = alarm_hit_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Scoreboard bench for rtc_calendar: the driver pushes the hand-computed state expected
// after each driven cycle; a monitor pops and compares after every clock edge.
module tb_rtc_calendar;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        set_en = 1'b0;
  logic [15:0] set_year = '0;
  logic [3:0]  set_month = '0;
  logic [4:0]  set_day = '0;
  logic [4:0]  set_hour = '0;
  logic [5:0]  set_min = '0;
  logic [5:0]  set_sec = '0;
  logic [2:0]  set_wday = '0;
  logic        alarm_en = 1'b0;
  logic [4:0]  alarm_hour = '0;
  logic [5:0]  alarm_min = '0;
  logic [5:0]  alarm_sec = '0;
  logic [15:0] year;
  logic [3:0]  month;
  logic [4:0]  day;
  logic [4:0]  hour;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic [2:0]  wday;
  logic        leap, min_carry, day_carry, set_err, alarm_hit;

  rtc_calendar dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .set_en     (set_en),
    .set_year   (set_year),
    .set_month  (set_month),
    .set_day    (set_day),
    .set_hour   (set_hour),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .set_wday   (set_wday),
    .alarm_en   (alarm_en),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_sec  (alarm_sec),
    .year       (year),
    .month      (month),
    .day        (day),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .wday       (wday),
    .leap       (leap),
    .min_carry  (min_carry),
    .day_carry  (day_carry),
    .set_err    (set_err),
    .alarm_hit  (alarm_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [4:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic [2:0]  wday;
    logic        leap, mc, dc, se, ah;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic exp_t mk(input string nm, input int y, input int m, input int d,
                              input int h, input int mi, input int s, input int w,
                              input int lp, input int mc, input int dc, input int se,
                              input int ah);
    exp_t e;
    e.name = nm;     e.year = 16'(y);   e.month = 4'(m);  e.day = 5'(d);
    e.hour = 5'(h);  e.minute = 6'(mi); e.second = 6'(s); e.wday = 3'(w);
    e.leap = lp[0];  e.mc = mc[0];      e.dc = dc[0];     e.se = se[0];
    e.ah = ah[0];
    return e;
  endfunction

  // Monitor: outputs are registered, so sample 2 time units after the active edge.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (year !== mon_e.year || month !== mon_e.month || day !== mon_e.day ||
          hour !== mon_e.hour || minute !== mon_e.minute || second !== mon_e.second ||
          wday !== mon_e.wday || leap !== mon_e.leap || min_carry !== mon_e.mc ||
          day_carry !== mon_e.dc || set_err !== mon_e.se || alarm_hit !== mon_e.ah) begin
        n_fail++;
        $display("FAIL %s: got %0d-%0d-%0d %0d:%0d:%0d w%0d lp%0b mc%0b dc%0b se%0b ah%0b, expected %0d-%0d-%0d %0d:%0d:%0d w%0d lp%0b mc%0b dc%0b se%0b ah%0b",
                 mon_e.name, year, month, day, hour, minute, second, wday, leap,
                 min_carry, day_carry, set_err, alarm_hit,
                 mon_e.year, mon_e.month, mon_e.day, mon_e.hour, mon_e.minute,
                 mon_e.second, mon_e.wday, mon_e.leap, mon_e.mc, mon_e.dc, mon_e.se,
                 mon_e.ah);
      end
    end
  end

  task automatic set_vals(input int y, input int m, input int d, input int h, input int mi,
                          input int s, input int w);
    set_year = 16'(y); set_month = 4'(m); set_day = 5'(d);
    set_hour = 5'(h);  set_min = 6'(mi);  set_sec = 6'(s); set_wday = 3'(w);
  endtask

  task automatic step(input logic t, input logic se, input exp_t e);
    @(negedge clk);
    tick = t;
    set_en = se;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tick = 1'b0;
    set_en = 1'b0;
  endtask

  typedef struct {
    int y; int lp; int m_n; int d_n;
  } leap_vec_t;

  leap_vec_t lv[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    lv[0] = '{2024, 1, 2, 29};
    lv[1] = '{2023, 0, 3, 1};
    lv[2] = '{2100, 0, 3, 1};
    lv[3] = '{2000, 1, 2, 29};

    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state, then 61 ticks with one minute carry on the 60th.
    step(1'b0, 1'b0, mk("reset", 2021, 5, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 61; i++)
      step(1'b1, 1'b0, mk("tick61", 2021, 5, 30, 0, i / 60, i % 60, 0, 0,
                          (i == 60) ? 1 : 0, 0, 0, 0));
    step(1'b0, 1'b0, mk("hold", 2021, 5, 30, 0, 1, 1, 0, 0, 0, 0, 0, 0));

    // Feb 28 23:59:59 rollover for leap and non-leap years.
    foreach (lv[k]) begin
      set_vals(lv[k].y, 2, 28, 23, 59, 59, 3);
      step(1'b0, 1'b1, mk("feb_load", lv[k].y, 2, 28, 23, 59, 59, 3, lv[k].lp, 0, 0, 0, 0));
      step(1'b1, 1'b0, mk("feb_roll", lv[k].y, lv[k].m_n, lv[k].d_n, 0, 0, 0, 4, lv[k].lp,
                          1, 1, 0, 0));
    end

    // Full wrap past YEAR_MAX.
    set_vals(2399, 12, 31, 23, 59, 59, 6);
    step(1'b0, 1'b1, mk("wrap_load", 2399, 12, 31, 23, 59, 59, 6, 0, 0, 0, 0, 0));
    step(1'b1, 1'b0, mk("wrap", 2000, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0));

    // Rejected loads leave 2000-01-01 00:00:00 untouched.
    set_vals(2023, 2, 29, 12, 0, 0, 1);
    step(1'b0, 1'b1, mk("bad_feb29", 2000, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    step(1'b0, 1'b0, mk("err_clear", 2000, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    set_vals(2022, 13, 1, 12, 0, 0, 1);
    step(1'b0, 1'b1, mk("bad_month", 2000, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    step(1'b0, 1'b0, mk("err_clear", 2000, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    set_vals(2022, 1, 1, 24, 0, 0, 1);
    step(1'b0, 1'b1, mk("bad_hour", 2000, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    step(1'b0, 1'b0, mk("err_clear", 2000, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    set_vals(1999, 1, 1, 12, 0, 0, 1);
    step(1'b0, 1'b1, mk("bad_year", 2000, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    step(1'b0, 1'b0, mk("err_clear", 2000, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Load with a coincident tick: valid load wins, invalid load lets the tick through.
    set_vals(2022, 1, 1, 12, 0, 0, 6);
    step(1'b1, 1'b1, mk("load_tick", 2022, 1, 1, 12, 0, 0, 6, 0, 0, 0, 0, 0));
    set_vals(2022, 0, 1, 12, 0, 0, 6);
    step(1'b1, 1'b1, mk("bad_tick", 2022, 1, 1, 12, 0, 1, 6, 0, 0, 0, 1, 0));

    // Alarm at 07:30:00.
    @(negedge clk);
    alarm_hour = 5'd7; alarm_min = 6'd30; alarm_sec = 6'd0; alarm_en = 1'b1;
    set_vals(2022, 1, 1, 7, 29, 58, 6);
    step(1'b0, 1'b1, mk("al_load", 2022, 1, 1, 7, 29, 58, 6, 0, 0, 0, 0, 0));
    step(1'b1, 1'b0, mk("al_pre", 2022, 1, 1, 7, 29, 59, 6, 0, 0, 0, 0, 0));
    step(1'b1, 1'b0, mk("al_hit", 2022, 1, 1, 7, 30, 0, 6, 0, 1, 0, 0, 1));
    step(1'b1, 1'b0, mk("al_post", 2022, 1, 1, 7, 30, 1, 6, 0, 0, 0, 0, 0));
    set_vals(2022, 1, 1, 7, 30, 0, 6);
    step(1'b0, 1'b1, mk("al_loaded", 2022, 1, 1, 7, 30, 0, 6, 0, 0, 0, 0, 0));
    set_vals(2022, 1, 1, 7, 29, 59, 6);
    step(1'b0, 1'b1, mk("al_reload", 2022, 1, 1, 7, 29, 59, 6, 0, 0, 0, 0, 0));
    @(negedge clk);
    alarm_en = 1'b0;
    step(1'b1, 1'b0, mk("al_off", 2022, 1, 1, 7, 30, 0, 6, 0, 1, 0, 0, 0));

    // Reset asserted while min_carry is high.
    @(negedge clk);
    sb.push_back(mk("rst_mid", 2021, 5, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, mk("rst_after", 2021, 5, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
